// File: rtl/tinynpu_ctrl.sv
// ---------------------------------------------------------------------------
// tinynpu_ctrl : control unit for the TinyNPU datapath.
//
// Runs one tile per start pulse:
//   LOAD - accept SIZE x elements and SIZE elements for each of SIZE weight lanes
//   RUN  - SIZE lock-step pops of x and every weight FIFO, x fed back into its FIFO
//   OUT  - stream SIZE x FIFO entries onto z_out
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   start/busy/done       host handshake; done pulses on the last OUT cycle
//   z_out_val             datapath z_out carries a valid result this cycle
//   d2c_x_load_val        host x strobe
//   d2c_w_load_val/_sel   host w strobe and target weight lane
//   d2c_x_fifo_empty      x FIFO empty
//   d2c_w_fifo_empty[i]   weight lane i FIFO empty
//   c2d_x_sel             0: host x_in, 1: feedback into x FIFO
//   c2d_x_fifo_wen/_ren   x FIFO write / pop
//   c2d_w_fifo_wen[i]     weight lane i write
//   c2d_w_fifo_ren        pop shared by all weight lanes
//   c2d_z_out_sel         0: z_out=0, 1: z_out=x FIFO head
//
// Optional build macro TINYNPU_CTRL_PERF_EN adds perf_busy_cycles and
// perf_stall_cycles (32-bit, saturating, cleared only by rst).
//
// All outputs are combinational from registered state/counters plus inputs.
// ---------------------------------------------------------------------------

// Per-lane weight load counter: gates the lane write and reports when the
// lane would be full after this cycle's write.
module tinynpu_ctrl_wlane #(
    parameter int SIZE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,      // controller is in LOAD
    input  logic req,     // host strobe addressed to this lane
    input  logic clr,     // leaving LOAD this cycle
    output logic wen,
    output logic full
);
    localparam int CW = $clog2(SIZE) + 1;
    localparam logic [CW-1:0] SIZE_C = CW'(SIZE);

    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;

    always_comb begin
        wen     = en & req & (cnt_q < SIZE_C);
        cnt_inc = cnt_q + {{(CW-1){1'b0}}, wen};
        full    = (cnt_inc == SIZE_C);
        cnt_d   = clr ? '0 : cnt_inc;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

module tinynpu_ctrl #(
    parameter int SIZE  = 4,
    parameter int NBITS = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    z_out_val,
    input  logic                    d2c_x_load_val,
    input  logic                    d2c_w_load_val,
    input  logic [$clog2(SIZE)-1:0] d2c_w_load_sel,
    input  logic                    d2c_x_fifo_empty,
    input  logic                    d2c_w_fifo_empty [SIZE],
    output logic                    c2d_x_sel,
    output logic                    c2d_x_fifo_wen,
    output logic                    c2d_w_fifo_wen [SIZE],
    output logic                    c2d_x_fifo_ren,
    output logic                    c2d_w_fifo_ren,
    output logic                    c2d_z_out_sel
`ifdef TINYNPU_CTRL_PERF_EN
    ,
    output logic [31:0]             perf_busy_cycles,
    output logic [31:0]             perf_stall_cycles
`endif
);
    localparam int CW = $clog2(SIZE) + 1;
    localparam int SW = $clog2(SIZE);
    localparam logic [CW-1:0] SIZE_C = CW'(SIZE);
    localparam logic [CW-1:0] LAST_C = CW'(SIZE - 1);

    // No data passes through here; NBITS only has to be sane.
    if (NBITS < 1 || SIZE < 2) begin : g_bad_params
    end

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_OUT} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] x_cnt_q, x_cnt_d;
    logic [CW-1:0] run_cnt_q, run_cnt_d;
    logic [CW-1:0] out_cnt_q, out_cnt_d;
    logic [CW-1:0] x_inc;

    logic            load_en, load_clr, w_any_empty, fire;
    logic [SIZE-1:0] w_full;

    assign load_en = (state_q == ST_LOAD);

    for (genvar i = 0; i < SIZE; i++) begin : g_lane
        tinynpu_ctrl_wlane #(.SIZE(SIZE)) u_lane (
            .clk  (clk),
            .rst  (rst),
            .en   (load_en),
            .req  (d2c_w_load_val & (d2c_w_load_sel == SW'(i))),
            .clr  (load_clr),
            .wen  (c2d_w_fifo_wen[i]),
            .full (w_full[i])
        );
    end

    always_comb begin
        busy           = (state_q != ST_IDLE);
        done           = 1'b0;
        z_out_val      = 1'b0;
        c2d_x_sel      = 1'b0;
        c2d_x_fifo_wen = 1'b0;
        c2d_x_fifo_ren = 1'b0;
        c2d_w_fifo_ren = 1'b0;
        c2d_z_out_sel  = 1'b0;
        load_clr       = 1'b0;
        state_d        = state_q;
        x_cnt_d        = x_cnt_q;
        run_cnt_d      = run_cnt_q;
        out_cnt_d      = out_cnt_q;
        x_inc          = x_cnt_q;

        w_any_empty = 1'b0;
        for (int i = 0; i < SIZE; i++) w_any_empty = w_any_empty | d2c_w_fifo_empty[i];
        fire = ~d2c_x_fifo_empty & ~w_any_empty;

        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                c2d_x_fifo_wen = d2c_x_load_val & (x_cnt_q < SIZE_C);
                x_inc          = x_cnt_q + {{(CW-1){1'b0}}, c2d_x_fifo_wen};
                // Completion counts this cycle's writes, so RUN starts the
                // cycle right after the final accepted write.
                if (x_inc == SIZE_C && &w_full) begin
                    state_d   = ST_RUN;
                    load_clr  = 1'b1;
                    x_cnt_d   = '0;
                    run_cnt_d = '0;
                end else begin
                    x_cnt_d = x_inc;
                end
            end
            ST_RUN: begin
                if (fire) begin
                    c2d_x_fifo_ren = 1'b1;
                    c2d_w_fifo_ren = 1'b1;
                    c2d_x_sel      = 1'b1;
                    c2d_x_fifo_wen = 1'b1;   // feedback value goes back into x FIFO
                    run_cnt_d      = run_cnt_q + 1'b1;
                    if (run_cnt_q == LAST_C) begin
                        state_d   = ST_OUT;
                        out_cnt_d = '0;
                    end
                end
            end
            ST_OUT: begin
                c2d_z_out_sel = 1'b1;
                if (!d2c_x_fifo_empty) begin
                    c2d_x_fifo_ren = 1'b1;
                    z_out_val      = 1'b1;
                    out_cnt_d      = out_cnt_q + 1'b1;
                    if (out_cnt_q == LAST_C) begin
                        done      = 1'b1;
                        state_d   = ST_IDLE;
                        out_cnt_d = '0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef TINYNPU_CTRL_PERF_EN
    logic [31:0] perf_busy_q, perf_busy_d, perf_stall_q, perf_stall_d;
    logic        stall;

    always_comb begin
        stall = ((state_q == ST_RUN) & ~fire) | ((state_q == ST_OUT) & d2c_x_fifo_empty);
        perf_busy_d  = perf_busy_q;
        perf_stall_d = perf_stall_q;
        if (busy  && perf_busy_q  != 32'hFFFF_FFFF) perf_busy_d  = perf_busy_q + 32'd1;
        if (stall && perf_stall_q != 32'hFFFF_FFFF) perf_stall_d = perf_stall_q + 32'd1;
    end

    assign perf_busy_cycles  = perf_busy_q;
    assign perf_stall_cycles = perf_stall_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            x_cnt_q   <= '0;
            run_cnt_q <= '0;
            out_cnt_q <= '0;
`ifdef TINYNPU_CTRL_PERF_EN
            perf_busy_q  <= '0;
            perf_stall_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            x_cnt_q   <= x_cnt_d;
            run_cnt_q <= run_cnt_d;
            out_cnt_q <= out_cnt_d;
`ifdef TINYNPU_CTRL_PERF_EN
            perf_busy_q  <= perf_busy_d;
            perf_stall_q <= perf_stall_d;
`endif
        end
    end
endmodule

// File: tb/tb_tinynpu_ctrl.sv
// Directed bench for tinynpu_ctrl (SIZE=4). A small occupancy model of the
// datapath FIFOs produces the empty flags; lane 1 can be forced empty.
module tb_tinynpu_ctrl;
    localparam int SIZE = 4;

    logic       clk = 1'b0;
    logic       rst, start;
    logic       busy, done, z_out_val;
    logic       d2c_x_load_val, d2c_w_load_val;
    logic [1:0] d2c_w_load_sel;
    logic       d2c_x_fifo_empty;
    logic       d2c_w_fifo_empty [SIZE];
    logic       c2d_x_sel, c2d_x_fifo_wen, c2d_x_fifo_ren, c2d_w_fifo_ren, c2d_z_out_sel;
    logic       c2d_w_fifo_wen [SIZE];
`ifdef TINYNPU_CTRL_PERF_EN
    logic [31:0] perf_busy_cycles, perf_stall_cycles;
`endif

    int  vecs = 0;
    int  errs = 0;
    int  x_occ;
    int  w_occ [SIZE];
    bit  force1 = 1'b0;

    always #5 clk = ~clk;

    tinynpu_ctrl #(.SIZE(SIZE), .NBITS(8)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .z_out_val(z_out_val),
        .d2c_x_load_val(d2c_x_load_val), .d2c_w_load_val(d2c_w_load_val),
        .d2c_w_load_sel(d2c_w_load_sel), .d2c_x_fifo_empty(d2c_x_fifo_empty),
        .d2c_w_fifo_empty(d2c_w_fifo_empty),
        .c2d_x_sel(c2d_x_sel), .c2d_x_fifo_wen(c2d_x_fifo_wen),
        .c2d_w_fifo_wen(c2d_w_fifo_wen), .c2d_x_fifo_ren(c2d_x_fifo_ren),
        .c2d_w_fifo_ren(c2d_w_fifo_ren), .c2d_z_out_sel(c2d_z_out_sel)
`ifdef TINYNPU_CTRL_PERF_EN
        , .perf_busy_cycles(perf_busy_cycles), .perf_stall_cycles(perf_stall_cycles)
`endif
    );

    // Datapath FIFO occupancy model.
    always @(posedge clk) begin
        if (rst) begin
            x_occ <= 0;
            for (int i = 0; i < SIZE; i++) w_occ[i] <= 0;
        end else begin
            x_occ <= x_occ + int'(c2d_x_fifo_wen) - int'(c2d_x_fifo_ren);
            for (int i = 0; i < SIZE; i++)
                w_occ[i] <= w_occ[i] + int'(c2d_w_fifo_wen[i]) - int'(c2d_w_fifo_ren);
        end
    end

    always_comb begin
        d2c_x_fifo_empty = (x_occ == 0);
        for (int i = 0; i < SIZE; i++)
            d2c_w_fifo_empty[i] = (w_occ[i] == 0) || (i == 1 && force1);
    end

    function automatic logic [3:0] wv();
        logic [3:0] v;
        for (int i = 0; i < SIZE; i++) v[i] = c2d_w_fifo_wen[i];
        return v;
    endfunction

    // {x_sel, x_wen, w_wen[3:0], x_ren, w_ren, z_sel}
    function automatic logic [8:0] c2d();
        return {c2d_x_sel, c2d_x_fifo_wen, wv(), c2d_x_fifo_ren, c2d_w_fifo_ren, c2d_z_out_sel};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic begin_tile(input bit hold_start);
        start = 1'b1;
        #1 chk("idle_busy", busy, 0);
        tick();
        start = hold_start;
        chk("load_busy", busy, 1);
    endtask

    // One LOAD cycle with the given strobes and expected write enables.
    task automatic xw(input bit xv, input bit wvl, input int sel,
                      input bit ex, input logic [3:0] ew);
        d2c_x_load_val = xv;
        d2c_w_load_val = wvl;
        d2c_w_load_sel = 2'(sel);
        #1;
        chk("x_wen", c2d_x_fifo_wen, ex);
        chk("w_wen", wv(), ew);
        tick();
        d2c_x_load_val = 1'b0;
        d2c_w_load_val = 1'b0;
    endtask

    task automatic load_w_all();
        for (int l = 0; l < SIZE; l++)
            for (int k = 0; k < SIZE; k++) xw(0, 1, l, 0, 4'(1 << l));
    endtask

    // RUN of SIZE+slen cycles with lane 1 forced empty for slen cycles from
    // cycle s0, then SIZE OUT cycles with done on the last one.
    task automatic run_out(input int s0, input int slen);
        for (int c = 0; c < SIZE + slen; c++) begin
            force1 = (c >= s0 && c < s0 + slen);
            #1;
            chk("run_c2d", c2d(), force1 ? 9'h000 : 9'b1_1_0000_1_1_0);
            chk("run_busy", busy, 1);
            tick();
        end
        force1 = 1'b0;
        for (int c = 0; c < SIZE; c++) begin
            #1;
            chk("out_c2d", c2d(), 9'b0_0_0000_1_0_1);
            chk("out_zval", z_out_val, 1);
            chk("out_done", done, (c == SIZE - 1));
            tick();
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0;
        d2c_x_load_val = 1'b0; d2c_w_load_val = 1'b0; d2c_w_load_sel = 2'd0;
        #2;
        do_reset();

        // Reset state.
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_zval", z_out_val, 0);
        chk("rst_c2d", c2d(), 0);

        // Load strobes in IDLE are ignored.
        xw(1, 1, 0, 0, 4'h0);

        // Reset during LOAD after 3 x writes.
        begin_tile(0);
        for (int k = 0; k < 3; k++) xw(1, 0, 0, 1, 4'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_c2d", c2d(), 0);

        // New tile needs all 4 x writes again.
        begin_tile(0);
        for (int k = 0; k < 3; k++) xw(1, 0, 0, 1, 4'h0);
        load_w_all();
        #1 chk("still_load", c2d(), 0);
        tick();
        xw(1, 0, 0, 1, 4'h0);
        run_out(0, 0);
        #1 chk("end_busy", busy, 0);
        chk("end_done", done, 0);

        // Overflow: 6 x strobes, 5 to lane 2.
        begin_tile(0);
        for (int k = 0; k < 6; k++) xw(1, 0, 0, (k < 4), 4'h0);
        for (int k = 0; k < 5; k++) xw(0, 1, 2, 0, (k < 4) ? 4'h4 : 4'h0);
        for (int k = 0; k < 4; k++) xw(0, 1, 0, 0, 4'h1);
        for (int k = 0; k < 4; k++) xw(0, 1, 1, 0, 4'h2);
        for (int k = 0; k < 4; k++) xw(0, 1, 3, 0, 4'h8);
        chk("ovf_xocc", 32'(x_occ), 4);
        chk("ovf_w2occ", 32'(w_occ[2]), 4);
        run_out(0, 0);

        // Simultaneous x and w writes; RUN follows the last write directly.
        begin_tile(0);
        for (int k = 0; k < 4; k++) xw(1, 1, 0, 1, 4'h1);
        for (int l = 1; l < SIZE; l++)
            for (int k = 0; k < SIZE; k++) xw(0, 1, l, 0, 4'(1 << l));
        run_out(0, 0);

        // Stall: lane 1 forced empty for 3 RUN cycles.
        do_reset();
        begin_tile(0);
        for (int k = 0; k < 4; k++) xw(1, 0, 0, 1, 4'h0);
        load_w_all();
        run_out(1, 3);
        #1 chk("stall_busy", busy, 0);
`ifdef TINYNPU_CTRL_PERF_EN
        chk("perf_stall", perf_stall_cycles, 3);
        chk("perf_busy", perf_busy_cycles, 20 + 7 + 4);
`endif

        // start held high through a tile: no restart while busy, then
        // IDLE for exactly one cycle before the next tile.
        begin_tile(1);
        for (int k = 0; k < 4; k++) xw(1, 1, 0, 1, 4'h1);
        for (int l = 1; l < SIZE; l++)
            for (int k = 0; k < SIZE; k++) xw(0, 1, l, 0, 4'(1 << l));
        run_out(0, 0);
        chk("held_idle", busy, 0);
        tick();
        chk("held_restart", busy, 1);
        start = 1'b0;
        do_reset();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/tinynpu_ctrl.md
Name: tinynpu_ctrl

Overview:
- Control unit for the TinyNPU datapath. Drives every c2d_* control and consumes every d2c_* status of the datapath.
- Sequences one tile per start: load phase (x vector plus SIZE weight lanes into FIFOs), compute phase (lock-step pops with x feedback), output phase (stream the x FIFO onto z_out).
- Sits between the host load interface and the datapath. Gives the host a start/busy/done handshake and an output-valid strobe.

Parameters:
- SIZE, 4, vector length, number of weight lanes, and depth of every FIFO (power of 2, at least 2)
- NBITS, 8, data width (carried for consistency; no data passes through this block)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin a tile; sampled only in IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on the last OUT cycle
- z_out_val  out  1  datapath z_out is valid this cycle
- d2c_x_load_val  in  1  host presents an x element
- d2c_w_load_val  in  1  host presents a w element
- d2c_w_load_sel  in  $clog2(SIZE)  target weight lane
- d2c_x_fifo_empty  in  1  x FIFO empty
- d2c_w_fifo_empty  in  1 x SIZE (unpacked)  per-lane weight FIFO empty
- c2d_x_sel  out  1  0 selects host x_in, 1 selects the feedback path
- c2d_x_fifo_wen  out  1  x FIFO write
- c2d_w_fifo_wen  out  1 x SIZE (unpacked)  per-lane weight FIFO write
- c2d_x_fifo_ren  out  1  x FIFO pop
- c2d_w_fifo_ren  out  1  pop, shared by all weight lanes
- c2d_z_out_sel  out  1  0 drives z_out=0, 1 drives z_out=x FIFO head

Behaviour:
- One clock; synchronous active-high reset. All outputs are combinational from the registered state and counters plus the current inputs.
- FIFOs are show-ahead: the head is visible on q while the FIFO is non-empty.
- Reset (including mid-tile): state=IDLE, all counters=0. busy, done, z_out_val and all c2d_* are 0. FIFO contents are cleared by the datapath's own reset.
- States: IDLE, LOAD, RUN, OUT.
- IDLE:
  - All c2d_* are 0.
  - start=1 -> LOAD next cycle.
  - Load strobes in IDLE are ignored (no wen).
- LOAD:
  - c2d_x_sel=0.
  - c2d_x_fifo_wen = d2c_x_load_val & (x_cnt<SIZE).
  - c2d_w_fifo_wen[i] = d2c_w_load_val & (d2c_w_load_sel==i) & (w_cnt[i]<SIZE). At most one lane is written per cycle.
  - Each counter increments on its own accepted write. Writes beyond SIZE per FIFO are dropped silently.
  - x and w writes in the same cycle are both accepted.
  - Transition: when x_cnt==SIZE and every w_cnt[i]==SIZE, counting the writes of the current cycle -> RUN next cycle. Clear all load counters and run_cnt.
- RUN (SIZE pop steps):
  - A step fires when x FIFO and all weight FIFOs are non-empty.
  - In a firing cycle: c2d_x_fifo_ren=1, c2d_w_fifo_ren=1, c2d_x_sel=1, c2d_x_fifo_wen=1 (the feedback value is written back into the x FIFO), and run_cnt increments.
  - If any FIFO is empty: all c2d_* are 0 and run_cnt holds (stall).
  - After the SIZE-th step -> OUT, out_cnt=0.
- OUT:
  - c2d_z_out_sel=1.
  - When the x FIFO is non-empty: c2d_x_fifo_ren=1, z_out_val=1, out_cnt increments.
  - When the x FIFO is empty: ren=0, z_out_val=0 (stall).
  - On the SIZE-th valid output: done=1 that cycle, then -> IDLE.
- start while busy: ignored. done never coincides with busy=0.
- Latency with no stalls:
  - start to first LOAD cycle: 1.
  - LOAD: at least SIZE*(SIZE+1) strobes when x and w are never loaded in the same cycle. As few as SIZE*SIZE cycles when x and w writes share cycles.
  - RUN: exactly SIZE cycles.
  - OUT: exactly SIZE cycles.
- Counter widths: $clog2(SIZE)+1 bits, so the value SIZE is representable. Counters never wrap.

Optional Feature:
- Macro TINYNPU_CTRL_PERF_EN.
- Defined:
  - Adds output perf_busy_cycles (32-bit) and perf_stall_cycles (32-bit).
  - perf_busy_cycles increments every cycle busy=1.
  - perf_stall_cycles increments every RUN/OUT cycle in which the step does not fire.
  - Both clear on rst only and saturate at 0xFFFFFFFF.
- Undefined: the ports and logic are absent. Behaviour is otherwise identical.

Test Plan:
- Reset: rst=1 during LOAD after 3 x writes -> next cycle state=IDLE, busy=0, all c2d_*=0. A new tile then requires exactly SIZE x writes again.
- Nominal tile, SIZE=4:
  - start, then 4 x strobes and 16 w strobes (lane sel 0..3, 4 each) -> 20 wen pulses routed to the correct lanes.
  - RUN: exactly 4 cycles of ren=1, x_sel=1, x wen=1.
  - OUT: 4 cycles of z_out_val=1, z_out_sel=1, done on the 4th; busy falls the next cycle.
- Overflow: 6 x strobes and 5 strobes to lane 2 -> only 4 x wen pulses and 4 lane-2 wen pulses; extras produce no wen.
- Simultaneous: x and w strobes in the same cycle -> both wen asserted. Transition to RUN happens the cycle after the last of the 20 writes.
- Stall: during RUN force d2c_w_fifo_empty[1]=1 for 3 cycles -> ren=0 for those 3 cycles, run_cnt held, RUN lasts 7 cycles. With PERF_EN, perf_stall_cycles=3.
- start held high through the whole tile -> no restart while busy; the next tile begins one cycle after returning to IDLE.
